dbus_bridge: RTL and testbench
==============================

Name: dbus_bridge

Overview:
- Parametrised data-port bridge between the CPU D port and NUM_DEV memory-mapped devices (DM, timers, UART, …).
- Decodes address windows, sequences each access through a request/ready FSM, and bounds device latency with a timeout.
- Reports unmapped or timed-out accesses as bus errors, which CP0 raises as AdEL/AdES.
- Aggregates device interrupt lines into the CPU HWINT vector.
- Successor to the fixed two-device bridge: adds arbitrary device count, wait-state devices, timeout and error reporting.

Parameters:
- NUM_DEV, 3, number of devices (1..6).
- DEV_BASE, {32'h7F10,32'h7F00,32'h0000}, packed NUM_DEV×32 window base addresses; device k uses slice k.
- DEV_MASK, {32'hFFFFFFF0,32'hFFFFFFF0,32'hFFFFC000}, packed NUM_DEV×32 window masks; hit_k = ((addr & mask_k) == base_k).
- TIMEOUT, 16, maximum ACCESS cycles before an error (≥2).
- INT_WIDTH, 6, HWINT width.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; one clock; reset is asynchronous and active-low.
- DAddr  in  32  CPU byte address.
- DREn  in  1  read request.
- DWEn  in  1  write request.
- DByteEn  in  4  write byte enables.
- DWData  in  32  write data.
- DRData  out  32  read data, valid while DReady=1.
- DReady  out  1  one-cycle completion pulse.
- bus_err  out  1  error flag, valid with DReady.
- dev_addr  out  32  latched address, broadcast to all devices.
- dev_byteen  out  4  latched byte enables.
- dev_wdata  out  32  latched write data.
- dev_ren  out  NUM_DEV  one-hot read strobe.
- dev_wen  out  NUM_DEV  one-hot write strobe.
- dev_rdata  in  NUM_DEV×32  packed device read data.
- dev_ready  in  NUM_DEV  device completion.
- dev_irq  in  NUM_DEV  level interrupt requests.
- HWINT  out  INT_WIDTH  interrupt vector to CP0.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0; irq synchroniser 0.
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE, DREn^DWEn=1, some window hits:
  - Latch addr, byteen, wdata, rw and the index k of the lowest-indexed hitting window.
  - Clear the counter; go to ACCESS.
- IDLE, request present but no window hits, or DREn&DWEn both 1: go to ERR.
- ACCESS:
  - Assert dev_ren[k] or dev_wen[k] (exactly one bit) every cycle.
  - If dev_ready[k]=1: capture dev_rdata[k] (writes capture 0) and go to RESP.
  - Else if counter == TIMEOUT-1: go to ERR.
  - Else increment the counter.
- RESP: DReady=1, DRData=captured data, bus_err=0; go to IDLE.
- ERR: DReady=1, DRData=0, bus_err=1; go to IDLE. No device strobe is issued.
- Latency:
  - Zero-wait device: request in cycle n, strobe in n+1, DReady in n+2.
  - Each device wait cycle adds 1.
  - Timeout: DReady in n+1+TIMEOUT.
  - Unmapped access: DReady in n+1.
- The CPU holds its request stable until DReady. A new request is accepted in IDLE on the cycle after RESP/ERR; there are no back-to-back pipelined accesses.
- Inputs are ignored outside IDLE. A request withdrawn mid-access does not abort it; the access completes normally.
- dev_ready from a non-selected device is ignored.
- Interrupts:
  - Each dev_irq bit passes through a 2-flop synchroniser.
  - HWINT[i] = sync_irq[i] for i<NUM_DEV; all other bits are 0 unless the optional feature drives them.
  - 2-cycle interrupt latency.
- Reset asserted mid-access: immediate return to IDLE, strobes drop asynchronously, no DReady is generated.

Optional Feature:
- Macro: DBUS_ERR_IRQ_EN.
- Defined:
  - A sticky err_pending flag is set on every ERR completion and drives HWINT[INT_WIDTH-1], OR-ed with any device line mapped there.
  - The flag is cleared by a write to address 32'h7F7C. That address is handled internally: zero-latency RESP, no device strobe, never an error.
  - Set and clear in the same cycle: set wins.
- Undefined: no flag, 32'h7F7C decodes normally (error unless it falls in a window), HWINT as above.

Decomposition:
- Shared package memory.vh: WORD width, default device bases/masks, the 32'h7F7C error-clear address, the TYPE_INT width.
- Bridge FSM state encoding is local to this block.
- One natural sub-module, dbus_decode: combinational priority window decoder producing hit and index for NUM_DEV windows. Instantiated once; reused by the instruction-side bridge later.

Test Plan:
- Read 32'h0000_0010, DM ready immediately with data 32'hDEADBEEF -> dev_ren=3'b001 one cycle, DReady 2 cycles after request, DRData=32'hDEADBEEF, bus_err=0.
- Write 32'h7F04, byteen 4'b0011, wdata 32'h1234, timer ready after 3 wait cycles -> dev_wen=3'b010 for 4 cycles, dev_byteen=4'b0011, DReady at cycle n+5.
- Read 32'h9000_0000 (unmapped) -> no strobes, DReady at n+1, bus_err=1, DRData=0.
- Read 32'h7F14, UART never ready, TIMEOUT=16 -> strobe held 16 cycles, DReady with bus_err=1 at n+17.
- dev_irq=3'b100 -> HWINT=6'b000100 two cycles later. With DBUS_ERR_IRQ_EN: after an unmapped access HWINT[5]=1; a write to 32'h7F7C clears it.
- Reset pulled low during ACCESS -> strobes 0 asynchronously; after release, the next request completes normally.

Source files
------------

// File: rtl/dbus_bridge_pkg.sv
// Shared definitions for the CPU data-port bridge.
// Holds the bus word width, the default three-device address map
// (DM, timer, UART), the internal error-clear address and the HWINT width.
// The bridge FSM state encoding is deliberately not here; it stays local
// to the bridge.
package dbus_bridge_pkg;

    localparam int WORD_W     = 32;
    localparam int TYPE_INT_W = 6;

    // Slice k of each vector belongs to device k (slice 0 = DM).
    localparam logic [3*WORD_W-1:0] DEF_DEV_BASE = {32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000};
    localparam logic [3*WORD_W-1:0] DEF_DEV_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_C000};

    // Writing here clears the sticky bus-error interrupt (optional feature).
    localparam logic [WORD_W-1:0] ERR_CLR_ADDR = 32'h0000_7F7C;

    // Width of a device index; one bit minimum so single-device builds stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dbus_bridge_if.sv
// CPU data-port bus between the CPU (master) and the bridge (slave).
// Signals:
//   DAddr, DREn, DWEn, DByteEn, DWData : request, driven by the CPU
//   DRData, DReady, bus_err            : completion, driven by the bridge
interface dbus_bridge_if;
    import dbus_bridge_pkg::*;

    logic [WORD_W-1:0] DAddr;
    logic              DREn;
    logic              DWEn;
    logic [3:0]        DByteEn;
    logic [WORD_W-1:0] DWData;
    logic [WORD_W-1:0] DRData;
    logic              DReady;
    logic              bus_err;

    modport master (
        output DAddr, DREn, DWEn, DByteEn, DWData,
        input  DRData, DReady, bus_err
    );

    modport slave (
        input  DAddr, DREn, DWEn, DByteEn, DWData,
        output DRData, DReady, bus_err
    );

endinterface

// File: rtl/dbus_bridge_decode.sv
// dbus_decode: combinational priority window decoder.
// Ports:
//   addr : byte address to decode
//   hit  : 1 when any window matches ((addr & mask_k) == base_k)
//   idx  : index of the lowest-numbered matching window (0 when no hit)
// Shared with the instruction-side bridge, so it carries no state.
module dbus_decode
    import dbus_bridge_pkg::*;
#(
    parameter int                          NUM_DEV  = 3,
    parameter logic [NUM_DEV*WORD_W-1:0]   DEV_BASE = DEF_DEV_BASE,
    parameter logic [NUM_DEV*WORD_W-1:0]   DEV_MASK = DEF_DEV_MASK
) (
    input  logic [WORD_W-1:0]             addr,
    output logic                          hit,
    output logic [idx_width(NUM_DEV)-1:0] idx
);

    localparam int IDX_W = idx_width(NUM_DEV);

    // Scan from the top down so the lowest matching index is written last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = NUM_DEV - 1; k >= 0; k--) begin
            if ((addr & DEV_MASK[k*WORD_W +: WORD_W]) == DEV_BASE[k*WORD_W +: WORD_W]) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/dbus_bridge.sv
// dbus_bridge: CPU data port to NUM_DEV memory-mapped devices.
// Each access is decoded, strobed to one device until it answers or the
// TIMEOUT expires, then completed with a one-cycle DReady pulse. Unmapped,
// ambiguous (read and write together) or timed-out accesses complete with
// bus_err=1 and DRData=0. Device interrupts are synchronised onto HWINT.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   cpu               : CPU data-port bus (slave side)
//   dev_addr/byteen/wdata : latched request, broadcast to all devices
//   dev_ren, dev_wen  : one-hot strobes, held through the access
//   dev_rdata, dev_ready : packed per-device read data and completion
//   dev_irq, HWINT    : device interrupt levels in, CP0 vector out
// Optional feature macro DBUS_ERR_IRQ_EN: a sticky error flag on
// HWINT[INT_WIDTH-1], cleared by a write to ERR_CLR_ADDR.
module dbus_bridge
    import dbus_bridge_pkg::*;
#(
    parameter int                          NUM_DEV   = 3,
    parameter logic [NUM_DEV*WORD_W-1:0]   DEV_BASE  = DEF_DEV_BASE,
    parameter logic [NUM_DEV*WORD_W-1:0]   DEV_MASK  = DEF_DEV_MASK,
    parameter int                          TIMEOUT   = 16,
    parameter int                          INT_WIDTH = TYPE_INT_W
) (
    input  logic                        clk,
    input  logic                        reset,
    dbus_bridge_if.slave                cpu,
    output logic [WORD_W-1:0]           dev_addr,
    output logic [3:0]                  dev_byteen,
    output logic [WORD_W-1:0]           dev_wdata,
    output logic [NUM_DEV-1:0]          dev_ren,
    output logic [NUM_DEV-1:0]          dev_wen,
    input  logic [NUM_DEV*WORD_W-1:0]   dev_rdata,
    input  logic [NUM_DEV-1:0]          dev_ready,
    input  logic [NUM_DEV-1:0]          dev_irq,
    output logic [INT_WIDTH-1:0]        HWINT
);

    localparam int IDX_W = idx_width(NUM_DEV);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int NI    = (NUM_DEV < INT_WIDTH) ? NUM_DEV : INT_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_ERR} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]  addr_q, addr_d;
    logic [WORD_W-1:0]  wdata_q, wdata_d;
    logic [WORD_W-1:0]  rdata_q, rdata_d;
    logic [3:0]         byteen_q, byteen_d;
    logic [NUM_DEV-1:0] ren_q, ren_d;
    logic [NUM_DEV-1:0] wen_q, wen_d;
    logic               dready_q, dready_d;
    logic               err_q, err_d;
    logic [NUM_DEV-1:0] irq_s1_q, irq_s2_q;
`ifdef DBUS_ERR_IRQ_EN
    logic               err_pend_q, err_pend_d;
`endif

    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic [NUM_DEV-1:0] hit_oh;
    logic               sel_ready;
    logic [WORD_W-1:0]  sel_rdata;

    dbus_decode #(
        .NUM_DEV  (NUM_DEV),
        .DEV_BASE (DEV_BASE),
        .DEV_MASK (DEV_MASK)
    ) u_decode (
        .addr (cpu.DAddr),
        .hit  (hit),
        .idx  (hit_idx)
    );

    assign hit_oh = NUM_DEV'(1) << hit_idx;

    // The live strobe doubles as the device select, so ready from any other
    // device is masked off. Only a read strobe lets data through; writes capture 0.
    assign sel_ready = |(dev_ready & (ren_q | wen_q));

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < NUM_DEV; k++) begin
            if (ren_q[k]) sel_rdata = sel_rdata | dev_rdata[k*WORD_W +: WORD_W];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        byteen_d = byteen_q;
        ren_d    = ren_q;
        wen_d    = wen_q;
        rdata_d  = rdata_q;
        dready_d = 1'b0;
        err_d    = 1'b0;
`ifdef DBUS_ERR_IRQ_EN
        err_pend_d = err_pend_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cpu.DREn | cpu.DWEn) begin
                    if (cpu.DREn & cpu.DWEn) begin
                        state_d  = S_ERR;
                        dready_d = 1'b1;
                        err_d    = 1'b1;
                        rdata_d  = '0;
                    end
`ifdef DBUS_ERR_IRQ_EN
                    // Internal register: answered straight away, never strobed.
                    else if (cpu.DWEn && (cpu.DAddr == ERR_CLR_ADDR)) begin
                        state_d    = S_RESP;
                        dready_d   = 1'b1;
                        rdata_d    = '0;
                        err_pend_d = 1'b0;
                    end
`endif
                    else if (hit) begin
                        state_d  = S_ACCESS;
                        cnt_d    = '0;
                        addr_d   = cpu.DAddr;
                        wdata_d  = cpu.DWData;
                        byteen_d = cpu.DByteEn;
                        ren_d    = cpu.DREn ? hit_oh : '0;
                        wen_d    = cpu.DWEn ? hit_oh : '0;
                    end else begin
                        state_d  = S_ERR;
                        dready_d = 1'b1;
                        err_d    = 1'b1;
                        rdata_d  = '0;
                    end
                end
            end
            S_ACCESS: begin
                if (sel_ready) begin
                    state_d  = S_RESP;
                    dready_d = 1'b1;
                    rdata_d  = sel_rdata;
                    ren_d    = '0;
                    wen_d    = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d  = S_ERR;
                    dready_d = 1'b1;
                    err_d    = 1'b1;
                    rdata_d  = '0;
                    ren_d    = '0;
                    wen_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                rdata_d = '0;
            end
            S_ERR: begin
                state_d = S_IDLE;
                rdata_d = '0;
`ifdef DBUS_ERR_IRQ_EN
                // Evaluated after any clear, so a coincident set wins.
                err_pend_d = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            byteen_q <= '0;
            ren_q    <= '0;
            wen_q    <= '0;
            rdata_q  <= '0;
            dready_q <= 1'b0;
            err_q    <= 1'b0;
            irq_s1_q <= '0;
            irq_s2_q <= '0;
`ifdef DBUS_ERR_IRQ_EN
            err_pend_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            byteen_q <= byteen_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            rdata_q  <= rdata_d;
            dready_q <= dready_d;
            err_q    <= err_d;
            irq_s1_q <= dev_irq;
            irq_s2_q <= irq_s1_q;
`ifdef DBUS_ERR_IRQ_EN
            err_pend_q <= err_pend_d;
`endif
        end
    end

    always_comb begin
        HWINT         = '0;
        HWINT[NI-1:0] = irq_s2_q[NI-1:0];
`ifdef DBUS_ERR_IRQ_EN
        HWINT[INT_WIDTH-1] = HWINT[INT_WIDTH-1] | err_pend_q;
`endif
    end

    assign cpu.DRData  = rdata_q;
    assign cpu.DReady  = dready_q;
    assign cpu.bus_err = err_q;
    assign dev_addr    = addr_q;
    assign dev_byteen  = byteen_q;
    assign dev_wdata   = wdata_q;
    assign dev_ren     = ren_q;
    assign dev_wen     = wen_q;

endmodule

// File: tb/tb_dbus_bridge.sv
// Testbench for dbus_bridge: fixed vector table, hand-written multi-cycle
// sequences (interrupts, foreign ready, withdrawn request, timeout edge,
// reset mid-access, error-clear address) and randomized accesses checked
// against a transaction-level model of the address map and device latency.
`timescale 1ns/1ps
module tb_dbus_bridge;

    localparam int ND = 3;
    localparam int TO = 16;
    localparam int IW = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dbus_bridge_if cpu_if();

    logic [31:0]    dev_addr;
    logic [3:0]     dev_byteen;
    logic [31:0]    dev_wdata;
    logic [ND-1:0]  dev_ren, dev_wen, dev_ready, dev_irq;
    logic [ND*32-1:0] dev_rdata;
    logic [IW-1:0]  HWINT;

    dbus_bridge #(.NUM_DEV(ND), .TIMEOUT(TO), .INT_WIDTH(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu        (cpu_if),
        .dev_addr   (dev_addr),
        .dev_byteen (dev_byteen),
        .dev_wdata  (dev_wdata),
        .dev_ren    (dev_ren),
        .dev_wen    (dev_wen),
        .dev_rdata  (dev_rdata),
        .dev_ready  (dev_ready),
        .dev_irq    (dev_irq),
        .HWINT      (HWINT)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- device models ----------------
    int          dev_wait[ND];   // wait cycles before ready; >= TO means never in time
    logic [31:0] dev_data[ND];
    logic [ND-1:0] noise = '0;   // ready asserted by devices that are not strobed
    int          scnt[ND];
    logic [31:0] tb_base[ND] = '{32'h0000_0000, 32'h0000_7F00, 32'h0000_7F10};
    logic [31:0] tb_mask[ND] = '{32'hFFFF_C000, 32'hFFFF_FFF0, 32'hFFFF_FFF0};

    always_comb begin
        dev_rdata = '0;
        for (int k = 0; k < ND; k++) dev_rdata[k*32 +: 32] = dev_data[k];
    end

    always @(negedge clk) begin
        for (int k = 0; k < ND; k++) begin
            if (dev_ren[k] | dev_wen[k]) begin
                dev_ready[k] = (scnt[k] == dev_wait[k]);
                scnt[k]++;
            end else begin
                scnt[k] = 0;
                dev_ready[k] = noise[k];
            end
        end
    end

    // ---------------- transaction model ----------------
    typedef struct {
        int lat; logic [31:0] data; logic err;
        logic [ND-1:0] rmask; logic [ND-1:0] wmask; int scyc;
    } exp_t;

    typedef struct {
        int lat; logic [31:0] data; logic err;
        logic [ND-1:0] rmask; logic [ND-1:0] wmask; int scyc; logic multi;
        logic [31:0] saddr; logic [3:0] sbe; logic [31:0] swd;
    } obs_t;

    function automatic exp_t predict(input logic [31:0] a, input logic rd, input logic wr);
        exp_t e;
        int k;
        e = '{default: 0};
        if (rd && wr) begin e.lat = 1; e.err = 1'b1; return e; end
`ifdef DBUS_ERR_IRQ_EN
        if (wr && a == 32'h0000_7F7C) begin e.lat = 1; return e; end
`endif
        k = -1;
        for (int i = ND - 1; i >= 0; i--) if ((a & tb_mask[i]) == tb_base[i]) k = i;
        if (k < 0) begin e.lat = 1; e.err = 1'b1; return e; end
        if (dev_wait[k] < TO) begin
            e.lat = 2 + dev_wait[k];
            e.scyc = dev_wait[k] + 1;
            e.data = rd ? dev_data[k] : 32'h0;
        end else begin
            e.lat = 1 + TO;
            e.scyc = TO;
            e.err = 1'b1;
        end
        if (rd) e.rmask = ND'(1) << k; else e.wmask = ND'(1) << k;
        return e;
    endfunction

    // Drive one request, observe until DReady (bounded). hold>0 withdraws the
    // request after that many cycles.
    task automatic run_access(input logic [31:0] a, input logic rd, input logic wr,
                              input logic [3:0] be, input logic [31:0] wd, input int hold,
                              output obs_t o);
        o = '{default: 0};
        @(negedge clk);
        cpu_if.DAddr = a; cpu_if.DByteEn = be; cpu_if.DWData = wd;
        cpu_if.DREn = rd; cpu_if.DWEn = wr;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if ((dev_ren | dev_wen) != '0) begin
                o.scyc++;
                o.rmask |= dev_ren;
                o.wmask |= dev_wen;
                if ($countones({dev_ren, dev_wen}) > 1) o.multi = 1'b1;
                o.saddr = dev_addr; o.sbe = dev_byteen; o.swd = dev_wdata;
            end
            if (cpu_if.DReady) begin
                o.lat = c; o.data = cpu_if.DRData; o.err = cpu_if.bus_err;
                break;
            end
            if (c == hold) begin cpu_if.DREn = 1'b0; cpu_if.DWEn = 1'b0; end
        end
        cpu_if.DREn = 1'b0; cpu_if.DWEn = 1'b0;
    endtask

    task automatic check_access(input string nm, input logic [31:0] a, input logic [3:0] be,
                                input logic [31:0] wd, input obs_t o, input exp_t e);
        chk({nm, ".latency"}, o.lat, e.lat);
        chk({nm, ".DRData"},  o.data, e.data);
        chk({nm, ".bus_err"}, {31'b0, o.err}, {31'b0, e.err});
        chk({nm, ".dev_ren"}, {29'b0, o.rmask}, {29'b0, e.rmask});
        chk({nm, ".dev_wen"}, {29'b0, o.wmask}, {29'b0, e.wmask});
        chk({nm, ".strobe_cycles"}, o.scyc, e.scyc);
        if (e.scyc > 0) begin
            chk({nm, ".onehot"},     {31'b0, o.multi}, 32'h0);
            chk({nm, ".dev_addr"},   o.saddr, a);
            chk({nm, ".dev_byteen"}, {28'b0, o.sbe}, {28'b0, be});
            chk({nm, ".dev_wdata"},  o.swd, wd);
        end
    endtask

    task automatic model_access(input string nm, input logic [31:0] a, input logic rd,
                                input logic wr, input logic [3:0] be, input logic [31:0] wd,
                                input int hold);
        exp_t e;
        obs_t o;
        e = predict(a, rd, wr);
        run_access(a, rd, wr, be, wd, hold, o);
        check_access(nm, a, be, wd, o, e);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] addr; logic rd; logic wr; logic [3:0] be; logic [31:0] wd;
        int lat; logic [31:0] data; logic err; logic [2:0] rmask; logic [2:0] wmask; int scyc;
    } vec_t;

    vec_t tbl[9];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        obs_t o;
        exp_t e;
        cpu_if.DAddr = '0; cpu_if.DREn = 1'b0; cpu_if.DWEn = 1'b0;
        cpu_if.DByteEn = '0; cpu_if.DWData = '0;
        dev_irq = '0;
        dev_wait = '{0, 3, 99};
        dev_data = '{32'hDEAD_BEEF, 32'h1111_2222, 32'h3333_4444};

        // addr rd wr be wd | lat data err rmask wmask scyc
        tbl[0] = '{32'h0000_0010, 1'b1, 1'b0, 4'hF, 32'h0,    2,  32'hDEAD_BEEF, 1'b0, 3'b001, 3'b000, 1};
        tbl[1] = '{32'h0000_7F04, 1'b0, 1'b1, 4'h3, 32'h1234, 5,  32'h0,         1'b0, 3'b000, 3'b010, 4};
        tbl[2] = '{32'h9000_0000, 1'b1, 1'b0, 4'hF, 32'h0,    1,  32'h0,         1'b1, 3'b000, 3'b000, 0};
        tbl[3] = '{32'h0000_7F14, 1'b1, 1'b0, 4'hF, 32'h0,    17, 32'h0,         1'b1, 3'b100, 3'b000, 16};
        tbl[4] = '{32'h0000_0010, 1'b1, 1'b1, 4'hF, 32'h55,   1,  32'h0,         1'b1, 3'b000, 3'b000, 0};
        tbl[5] = '{32'h0000_3FFC, 1'b1, 1'b0, 4'hF, 32'h0,    2,  32'hDEAD_BEEF, 1'b0, 3'b001, 3'b000, 1};
        tbl[6] = '{32'h0000_4000, 1'b1, 1'b0, 4'hF, 32'h0,    1,  32'h0,         1'b1, 3'b000, 3'b000, 0};
        tbl[7] = '{32'h0000_7F08, 1'b1, 1'b0, 4'hC, 32'h0,    5,  32'h1111_2222, 1'b0, 3'b010, 3'b000, 4};
        tbl[8] = '{32'h0000_7F18, 1'b0, 1'b1, 4'h1, 32'hA5,   17, 32'h0,         1'b1, 3'b000, 3'b100, 16};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset.DReady",   {31'b0, cpu_if.DReady}, 32'h0);
        chk("reset.bus_err",  {31'b0, cpu_if.bus_err}, 32'h0);
        chk("reset.DRData",   cpu_if.DRData, 32'h0);
        chk("reset.dev_ren",  {29'b0, dev_ren}, 32'h0);
        chk("reset.dev_wen",  {29'b0, dev_wen}, 32'h0);
        chk("reset.dev_addr", dev_addr, 32'h0);
        chk("reset.HWINT",    {26'b0, HWINT}, 32'h0);
        reset = 1'b1;

        // Interrupt synchroniser latency
        @(negedge clk);
        dev_irq = 3'b100;
        @(negedge clk);
        chk("irq.after1", {26'b0, HWINT}, 32'h0);
        @(negedge clk);
        chk("irq.after2", {26'b0, HWINT}, 32'h0000_0004);
        dev_irq = 3'b000;
        repeat (3) @(negedge clk);
        chk("irq.cleared", {26'b0, HWINT}, 32'h0);

        // Table
        for (int i = 0; i < 9; i++) begin
            e = '{tbl[i].lat, tbl[i].data, tbl[i].err, tbl[i].rmask, tbl[i].wmask, tbl[i].scyc};
            run_access(tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].be, tbl[i].wd, 0, o);
            check_access($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].be, tbl[i].wd, o, e);
        end

        // Ready from non-selected devices is ignored
        noise = 3'b101;
        model_access("noise", 32'h0000_7F04, 1'b1, 1'b0, 4'hF, 32'h0, 0);
        noise = 3'b000;

        // Request withdrawn after one cycle still completes
        model_access("withdraw", 32'h0000_7F0C, 1'b1, 1'b0, 4'hF, 32'h0, 1);

        // Ready on the last allowed cycle vs one cycle too late
        dev_wait[2] = TO - 1;
        model_access("edge_ok", 32'h0000_7F14, 1'b1, 1'b0, 4'hF, 32'h0, 0);
        dev_wait[2] = TO;
        model_access("edge_to", 32'h0000_7F14, 1'b1, 1'b0, 4'hF, 32'h0, 0);

        // Reset in the middle of an access
        @(negedge clk);
        cpu_if.DAddr = 32'h0000_7F14; cpu_if.DREn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid.strobe", {29'b0, dev_ren}, 32'h4);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid.ren_async", {29'b0, dev_ren}, 32'h0);
        chk("rst_mid.wen_async", {29'b0, dev_wen}, 32'h0);
        cpu_if.DREn = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid.no_ready", {31'b0, cpu_if.DReady}, 32'h0);
        end
        reset = 1'b1;
        model_access("after_rst", 32'h0000_0010, 1'b1, 1'b0, 4'hF, 32'h0, 0);

        // Error-clear address
        model_access("err_set", 32'h9000_0000, 1'b1, 1'b0, 4'hF, 32'h0, 0);
        @(negedge clk);
`ifdef DBUS_ERR_IRQ_EN
        chk("errirq.set", {31'b0, HWINT[IW-1]}, 32'h1);
`else
        chk("errirq.none", {26'b0, HWINT}, 32'h0);
`endif
        model_access("err_clr", 32'h0000_7F7C, 1'b0, 1'b1, 4'hF, 32'h0, 0);
        @(negedge clk);
        chk("errirq.after_clr", {26'b0, HWINT}, 32'h0);

        // Randomized accesses
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            logic rd, wr;
            int sel, rw, hold;
            for (int k = 0; k < ND; k++) begin
                dev_wait[k] = $urandom_range(0, 20);
                dev_data[k] = $urandom;
            end
            noise = ND'($urandom_range(0, 7));
            sel = $urandom_range(0, 4);
            case (sel)
                0:       a = {18'b0, 14'($urandom)};
                1:       a = 32'h0000_7F00 + 32'($urandom_range(0, 15));
                2:       a = 32'h0000_7F10 + 32'($urandom_range(0, 15));
                3:       a = $urandom;
                default: a = 32'h0000_7F20 + 32'($urandom_range(0, 15));
            endcase
            rw = $urandom_range(0, 9);
            rd = (rw == 0) || (rw[0] == 1'b1);
            wr = (rw == 0) || (rw[0] == 1'b0);
            hold = ($urandom_range(0, 3) == 0) ? 1 : 0;
            model_access($sformatf("rnd%0d", n), a, rd, wr, 4'($urandom), $urandom, hold);
        end
        noise = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
